// File: rtl/draw_rect_char_pkg.sv
// Shared VGA bus widths, text-box geometry and pipeline payload types for the text overlay.
// Used by draw_rect_char (optional blink enabled with DRAW_CHAR_BLINK_EN).
package draw_rect_char_pkg;

  localparam int HCNT_W    = 11;
  localparam int RGB_W     = 12;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int BOX_W     = CHAR_W * TEXT_COLS;
  localparam int BOX_H     = CHAR_H * TEXT_ROWS;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;

  localparam int BUS_W = $bits(vga_bus_t);

  // Glyph-bit selector travelling alongside the font ROM lookup.
  typedef struct packed {
    logic       in_box;
    logic [2:0] bit_idx;
  } pix_sel_t;

  localparam int SEL_W = $bits(pix_sel_t);

  // Half-open range test done in int so lo+len cannot overflow the 11-bit counter.
  function automatic logic in_range(logic [HCNT_W-1:0] v, int lo, int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/draw_rect_char_if.sv
// VGA timing/pixel bus; master drives it, slave consumes it.
interface draw_rect_char_if;
  import draw_rect_char_pkg::*;

  logic [HCNT_W-1:0] hcount;
  logic [HCNT_W-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic [RGB_W-1:0]  rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_rect_char_delay.sv
// vga_delay: reset-clearable WIDTH-bit shift register, CLK_DEL clocks deep (0 = wire).
module vga_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (CLK_DEL == 0) begin : g_pass
      assign dout_o = din_i;
    end else begin : g_sr
      logic [CLK_DEL-1:0][WIDTH-1:0] sr_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else begin
          sr_q[0] <= din_i;
          for (int i = 1; i < CLK_DEL; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign dout_o = sr_q[CLK_DEL-1];
    end
  endgenerate

endmodule

// File: rtl/draw_rect_char.sv
// Text overlay: addresses char/font ROMs from the timing counters and paints set glyph bits.
// Define DRAW_CHAR_BLINK_EN to blink the text every BLINK_FRAMES vsync edges.
module draw_rect_char
  import draw_rect_char_pkg::*;
#(
  parameter logic [HCNT_W-1:0] XPOS         = 11'd100,
  parameter logic [HCNT_W-1:0] YPOS         = 11'd100,
  parameter logic [RGB_W-1:0]  TEXT_COLOR   = 12'hFFF,
  parameter int                ROM_LAT      = 2,
  parameter int                BLINK_FRAMES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  draw_rect_char_if.slave  vga_in,
  draw_rect_char_if.master vga_out,
  input  logic [7:0]       char_pixels,
  output logic [7:0]       char_xy,
  output logic [3:0]       char_line
);

  vga_bus_t bus_in, bus_dly, bus_q;
  pix_sel_t sel_in, sel_dly;
  logic [6:0] dx;
  logic [7:0] dy;
  logic       in_box;
  logic       hidden;
  logic [7:0] char_xy_d, char_xy_q;

  assign bus_in.hcount = vga_in.hcount;
  assign bus_in.vcount = vga_in.vcount;
  assign bus_in.hsync  = vga_in.hsync;
  assign bus_in.vsync  = vga_in.vsync;
  assign bus_in.hblnk  = vga_in.hblnk;
  assign bus_in.vblnk  = vga_in.vblnk;
  assign bus_in.rgb    = vga_in.rgb;

  // Only the low bits of the box-relative offsets address the 16x16 cell grid.
  assign dx = 7'(vga_in.hcount - XPOS);
  assign dy = 8'(vga_in.vcount - YPOS);

  assign in_box = in_range(vga_in.hcount, int'(XPOS), BOX_W) &&
                  in_range(vga_in.vcount, int'(YPOS), BOX_H) &&
                  !vga_in.hblnk && !vga_in.vblnk;

  assign char_xy_d      = in_box ? {dy[7:4], dx[6:3]} : 8'h00;
  assign sel_in.in_box  = in_box;
  assign sel_in.bit_idx = 3'd7 - dx[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_xy_q <= '0;
    else        char_xy_q <= char_xy_d;
  end

  assign char_xy = char_xy_q;

  // Glyph line arrives at the font ROM in step with the char ROM's registered code.
  vga_delay #(.WIDTH(4), .CLK_DEL(ROM_LAT)) u_line_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (dy[3:0]),
    .dout_o (char_line)
  );

  vga_delay #(.WIDTH(SEL_W), .CLK_DEL(ROM_LAT + 1)) u_sel_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (sel_in),
    .dout_o (sel_dly)
  );

  vga_delay #(.WIDTH(BUS_W), .CLK_DEL(ROM_LAT + 1)) u_bus_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (bus_in),
    .dout_o (bus_dly)
  );

`ifdef DRAW_CHAR_BLINK_EN
  localparam int BLINK_W = $clog2(2 * BLINK_FRAMES);

  logic               vsync_prev_q;
  logic [BLINK_W-1:0] frame_q;

  // Counter only moves on a vsync rising edge, so visibility never flips mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      frame_q      <= '0;
    end else begin
      vsync_prev_q <= vga_in.vsync;
      if (vga_in.vsync && !vsync_prev_q)
        frame_q <= (frame_q == BLINK_W'(2 * BLINK_FRAMES - 1)) ? '0 : frame_q + BLINK_W'(1);
    end
  end

  assign hidden = (frame_q >= BLINK_W'(BLINK_FRAMES));
`else
  assign hidden = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_dly;
      if (sel_dly.in_box && char_pixels[sel_dly.bit_idx] && !hidden)
        bus_q.rgb <= TEXT_COLOR;
    end
  end

  assign vga_out.hcount = bus_q.hcount;
  assign vga_out.vcount = bus_q.vcount;
  assign vga_out.hsync  = bus_q.hsync;
  assign vga_out.vsync  = bus_q.vsync;
  assign vga_out.hblnk  = bus_q.hblnk;
  assign vga_out.vblnk  = bus_q.vblnk;
  assign vga_out.rgb    = bus_q.rgb;

endmodule
